// File: rtl/frog_game_pkg.sv
// ----------------------------------------------------------------------------
// frog_game_pkg
// Shared definitions for the frog crossing game controller:
//   - state_t    : FSM state encoding (also driven onto the STATE output)
//   - LIVES_W    : width of the lives counter
//   - SCORE_W    : width of the crossing counter
//   - SCORE_MAX  : saturation value of the crossing counter
//   - score_inc  : saturating increment of the crossing counter
// ----------------------------------------------------------------------------
package frog_game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PLAY = 3'd1,
        ST_HIT  = 3'd2,
        ST_WIN  = 3'd3,
        ST_OVER = 3'd4
    } state_t;

    localparam int LIVES_W = 2;
    localparam int SCORE_W = 4;
    localparam logic [SCORE_W-1:0] SCORE_MAX = 4'd15;

    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
        return (s == SCORE_MAX) ? s : s + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/frog_collision_det.sv
// ----------------------------------------------------------------------------
// frog_collision_det
// Purely combinational collision detector. Selects the vehicle row addressed
// by the frog row and tests the bit under the frog column.
//   px_in, py_in      : frog column / row
//   veh1_in..veh6_in  : vehicle occupancy of rows 1..6
//   hit_out           : frog stands on an occupied cell of a road row
// Row 0 (start bank) and the goal row never report a collision.
// ----------------------------------------------------------------------------
module frog_collision_det #(
    parameter int DATAWIDTH_BUS      = 8,
    parameter int DATAWIDTH_SELECTOR = 3,
    parameter int GOAL_ROW           = 7
) (
    input  logic [DATAWIDTH_SELECTOR-1:0] px_in,
    input  logic [DATAWIDTH_SELECTOR-1:0] py_in,
    input  logic [DATAWIDTH_BUS-1:0]      veh1_in,
    input  logic [DATAWIDTH_BUS-1:0]      veh2_in,
    input  logic [DATAWIDTH_BUS-1:0]      veh3_in,
    input  logic [DATAWIDTH_BUS-1:0]      veh4_in,
    input  logic [DATAWIDTH_BUS-1:0]      veh5_in,
    input  logic [DATAWIDTH_BUS-1:0]      veh6_in,
    output logic                          hit_out
);

    localparam logic [DATAWIDTH_SELECTOR-1:0] GOAL_Y = DATAWIDTH_SELECTOR'(GOAL_ROW);

    logic [DATAWIDTH_BUS-1:0] veh_rows [6];
    logic [5:0]               row_hit;
    logic                     px_ok;

    assign veh_rows[0] = veh1_in;
    assign veh_rows[1] = veh2_in;
    assign veh_rows[2] = veh3_in;
    assign veh_rows[3] = veh4_in;
    assign veh_rows[4] = veh5_in;
    assign veh_rows[5] = veh6_in;

    // A column beyond the bus width addresses no vehicle cell.
    assign px_ok = (32'(px_in) < 32'(DATAWIDTH_BUS));

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_row
            assign row_hit[gi] = (py_in == DATAWIDTH_SELECTOR'(gi + 1))
                               && (py_in != GOAL_Y)
                               && px_ok
                               && veh_rows[gi][px_in];
        end
    endgenerate

    assign hit_out = |row_hit;

endmodule

// File: rtl/frog_game_ctrl.sv
// ----------------------------------------------------------------------------
// frog_game_ctrl
// Game controller for a frog road-crossing game.
//   FROG_GAME_CTRL_CLOCK      : system clock
//   FROG_GAME_CTRL_RESET      : asynchronous active-high reset
//   FROG_GAME_CTRL_START      : start button level (edge detected internally)
//   FROG_GAME_CTRL_PX_IN/PY_IN: frog column / row
//   FROG_GAME_CTRL_VEHn_IN    : vehicle occupancy of road rows 1..6
//   FROG_GAME_CTRL_INI_OUT    : one-cycle pulse, frog back to start position
//   FROG_GAME_CTRL_FREEZE_OUT : halts vehicles (high everywhere but PLAY)
//   FROG_GAME_CTRL_BLINK_OUT  : display blank strobe while in HIT
//   FROG_GAME_CTRL_LIVES_OUT  : remaining lives
//   FROG_GAME_CTRL_SCORE_OUT  : completed crossings (saturating)
//   FROG_GAME_CTRL_STATE_OUT  : current FSM state code
// ----------------------------------------------------------------------------
module frog_game_ctrl
    import frog_game_pkg::*;
#(
    parameter int DATAWIDTH_BUS      = 8,
    parameter int DATAWIDTH_SELECTOR = 3,
    parameter int LIVES_INI          = 3,
    parameter int HOLD_CYCLES        = 25000000,
    parameter int BLINK_DIV          = 6250000,
    parameter int GOAL_ROW           = 7
) (
    input  logic                          FROG_GAME_CTRL_CLOCK,
    input  logic                          FROG_GAME_CTRL_RESET,
    input  logic                          FROG_GAME_CTRL_START,
    input  logic [DATAWIDTH_SELECTOR-1:0] FROG_GAME_CTRL_PX_IN,
    input  logic [DATAWIDTH_SELECTOR-1:0] FROG_GAME_CTRL_PY_IN,
    input  logic [DATAWIDTH_BUS-1:0]      FROG_GAME_CTRL_VEH1_IN,
    input  logic [DATAWIDTH_BUS-1:0]      FROG_GAME_CTRL_VEH2_IN,
    input  logic [DATAWIDTH_BUS-1:0]      FROG_GAME_CTRL_VEH3_IN,
    input  logic [DATAWIDTH_BUS-1:0]      FROG_GAME_CTRL_VEH4_IN,
    input  logic [DATAWIDTH_BUS-1:0]      FROG_GAME_CTRL_VEH5_IN,
    input  logic [DATAWIDTH_BUS-1:0]      FROG_GAME_CTRL_VEH6_IN,
    output logic                          FROG_GAME_CTRL_INI_OUT,
    output logic                          FROG_GAME_CTRL_FREEZE_OUT,
    output logic                          FROG_GAME_CTRL_BLINK_OUT,
    output logic [LIVES_W-1:0]            FROG_GAME_CTRL_LIVES_OUT,
    output logic [SCORE_W-1:0]            FROG_GAME_CTRL_SCORE_OUT,
    output logic [2:0]                    FROG_GAME_CTRL_STATE_OUT
);

    localparam logic [31:0] HOLD_LOAD  = 32'(HOLD_CYCLES - 1);
    localparam logic [31:0] BLINK_LOAD = 32'(BLINK_DIV - 1);
    localparam logic [DATAWIDTH_SELECTOR-1:0] GOAL_Y = DATAWIDTH_SELECTOR'(GOAL_ROW);

    state_t               state_q,     state_d;
    logic [LIVES_W-1:0]   lives_q,     lives_d;
    logic [SCORE_W-1:0]   score_q,     score_d;
    logic [31:0]          timer_q,     timer_d;
    logic [31:0]          blink_cnt_q, blink_cnt_d;
    logic                 blink_q,     blink_d;
    logic                 ini_q,       ini_d;
    logic                 start_prev_q;

    logic start_edge;
    logic hit;
    logic goal;

    frog_collision_det #(
        .DATAWIDTH_BUS      (DATAWIDTH_BUS),
        .DATAWIDTH_SELECTOR (DATAWIDTH_SELECTOR),
        .GOAL_ROW           (GOAL_ROW)
    ) u_collision (
        .px_in   (FROG_GAME_CTRL_PX_IN),
        .py_in   (FROG_GAME_CTRL_PY_IN),
        .veh1_in (FROG_GAME_CTRL_VEH1_IN),
        .veh2_in (FROG_GAME_CTRL_VEH2_IN),
        .veh3_in (FROG_GAME_CTRL_VEH3_IN),
        .veh4_in (FROG_GAME_CTRL_VEH4_IN),
        .veh5_in (FROG_GAME_CTRL_VEH5_IN),
        .veh6_in (FROG_GAME_CTRL_VEH6_IN),
        .hit_out (hit)
    );

    assign start_edge = FROG_GAME_CTRL_START & ~start_prev_q;
    assign goal       = (FROG_GAME_CTRL_PY_IN == GOAL_Y);

    always_ff @(posedge FROG_GAME_CTRL_CLOCK or posedge FROG_GAME_CTRL_RESET) begin
        if (FROG_GAME_CTRL_RESET) begin
            state_q      <= ST_IDLE;
            lives_q      <= '0;
            score_q      <= '0;
            timer_q      <= '0;
            blink_cnt_q  <= '0;
            blink_q      <= 1'b0;
            ini_q        <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            score_q      <= score_d;
            timer_q      <= timer_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_q      <= blink_d;
            ini_q        <= ini_d;
            start_prev_q <= FROG_GAME_CTRL_START;
        end
    end

    // INI and BLINK are computed for the next state and registered, so they
    // line up with the first cycle of the state they belong to and are
    // glitch-free.
    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        score_d     = score_q;
        timer_d     = timer_q;
        blink_cnt_d = blink_cnt_q;
        blink_d     = 1'b0;
        ini_d       = 1'b0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_edge) begin
                    state_d = ST_PLAY;
                    lives_d = LIVES_W'(LIVES_INI);
                    score_d = '0;
                    ini_d   = 1'b1;
                end
            end

            ST_PLAY: begin
                // Collision wins over reaching the goal in the same cycle.
                if (hit) begin
                    state_d     = ST_HIT;
                    timer_d     = HOLD_LOAD;
                    blink_d     = 1'b1;
                    blink_cnt_d = BLINK_LOAD;
                end else if (goal) begin
                    state_d = ST_WIN;
                    timer_d = HOLD_LOAD;
                    score_d = score_inc(score_q);
                end
            end

            ST_HIT: begin
                if (timer_q == '0) begin
                    if (lives_q != '0) begin
                        lives_d = lives_q - LIVES_W'(1);
                    end
                    if (lives_q <= LIVES_W'(1)) begin
                        state_d = ST_OVER;
                    end else begin
                        state_d = ST_PLAY;
                        ini_d   = 1'b1;
                    end
                end else begin
                    timer_d = timer_q - 32'd1;
                    if (blink_cnt_q == '0) begin
                        blink_d     = ~blink_q;
                        blink_cnt_d = BLINK_LOAD;
                    end else begin
                        blink_d     = blink_q;
                        blink_cnt_d = blink_cnt_q - 32'd1;
                    end
                end
            end

            ST_WIN: begin
                if (timer_q == '0) begin
                    state_d = ST_PLAY;
                    ini_d   = 1'b1;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign FROG_GAME_CTRL_INI_OUT    = ini_q;
    assign FROG_GAME_CTRL_FREEZE_OUT = (state_q != ST_PLAY);
    assign FROG_GAME_CTRL_BLINK_OUT  = blink_q;
    assign FROG_GAME_CTRL_LIVES_OUT  = lives_q;
    assign FROG_GAME_CTRL_SCORE_OUT  = score_q;
    assign FROG_GAME_CTRL_STATE_OUT  = state_q;

endmodule

// File: tb/tb_frog_game_ctrl.sv
// ----------------------------------------------------------------------------
// tb_frog_game_ctrl
// Directed bench for frog_game_ctrl with HOLD_CYCLES=4, BLINK_DIV=2,
// LIVES_INI=3. Each step pushes the expected output snapshot for the coming
// cycle onto a scoreboard queue; after the clock edge the snapshot is popped
// and compared with the DUT outputs.
// ----------------------------------------------------------------------------
module tb_frog_game_ctrl;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PLAY = 3'd1;
    localparam logic [2:0] S_HIT  = 3'd2;
    localparam logic [2:0] S_WIN  = 3'd3;
    localparam logic [2:0] S_OVER = 3'd4;

    typedef struct packed {
        logic [2:0] st;
        logic       ini;
        logic       frz;
        logic       blk;
        logic [1:0] lv;
        logic [3:0] sc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] px = '0;
    logic [2:0] py = '0;
    logic [7:0] veh1 = '0, veh2 = '0, veh3 = '0, veh4 = '0, veh5 = '0, veh6 = '0;

    logic       ini_out, freeze_out, blink_out;
    logic [1:0] lives_out;
    logic [3:0] score_out;
    logic [2:0] state_out;

    exp_t  exp_q [$];
    string tag_q [$];
    int    n_cmp = 0;
    int    n_err = 0;

    logic [1:0] m_lives = '0;
    logic [3:0] m_score = '0;

    always #5 clk = ~clk;

    frog_game_ctrl #(
        .DATAWIDTH_BUS      (8),
        .DATAWIDTH_SELECTOR (3),
        .LIVES_INI          (3),
        .HOLD_CYCLES        (4),
        .BLINK_DIV          (2),
        .GOAL_ROW           (7)
    ) dut (
        .FROG_GAME_CTRL_CLOCK      (clk),
        .FROG_GAME_CTRL_RESET      (rst),
        .FROG_GAME_CTRL_START      (start),
        .FROG_GAME_CTRL_PX_IN      (px),
        .FROG_GAME_CTRL_PY_IN      (py),
        .FROG_GAME_CTRL_VEH1_IN    (veh1),
        .FROG_GAME_CTRL_VEH2_IN    (veh2),
        .FROG_GAME_CTRL_VEH3_IN    (veh3),
        .FROG_GAME_CTRL_VEH4_IN    (veh4),
        .FROG_GAME_CTRL_VEH5_IN    (veh5),
        .FROG_GAME_CTRL_VEH6_IN    (veh6),
        .FROG_GAME_CTRL_INI_OUT    (ini_out),
        .FROG_GAME_CTRL_FREEZE_OUT (freeze_out),
        .FROG_GAME_CTRL_BLINK_OUT  (blink_out),
        .FROG_GAME_CTRL_LIVES_OUT  (lives_out),
        .FROG_GAME_CTRL_SCORE_OUT  (score_out),
        .FROG_GAME_CTRL_STATE_OUT  (state_out)
    );

    // FREEZE is low only in PLAY.
    function automatic exp_t mk(input logic [2:0] st, input logic ini, input logic blk,
                                input logic [1:0] lv, input logic [3:0] sc);
        exp_t e;
        e.st  = st;
        e.ini = ini;
        e.frz = (st != S_PLAY);
        e.blk = blk;
        e.lv  = lv;
        e.sc  = sc;
        return e;
    endfunction

    task automatic set_veh(input logic [7:0] v);
        veh1 = v; veh2 = v; veh3 = v; veh4 = v; veh5 = v; veh6 = v;
    endtask

    task automatic check_pop();
        exp_t  e;
        exp_t  o;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o = {state_out, ini_out, freeze_out, blink_out, lives_out, score_out};
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed st=%0d ini=%0b frz=%0b blk=%0b lives=%0d score=%0d, required st=%0d ini=%0b frz=%0b blk=%0b lives=%0d score=%0d",
                   t, o.st, o.ini, o.frz, o.blk, o.lv, o.sc,
                   e.st, e.ini, e.frz, e.blk, e.lv, e.sc);
        end
        $display("t=%0t %s st=%0d ini=%0b frz=%0b blk=%0b lives=%0d score=%0d",
                 $time, t, o.st, o.ini, o.frz, o.blk, o.lv, o.sc);
    endtask

    // Expectation for the outputs right now (no clock edge).
    task automatic now_chk(input string tag, input exp_t e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        check_pop();
    endtask

    // Expectation for the outputs after the next clock edge.
    task automatic cyc(input string tag, input exp_t e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        check_pop();
    endtask

    task automatic hit_seq(input string tag, input logic [2:0] x, input logic [2:0] y);
        px = x;
        py = y;
        set_veh(8'(1 << x));
        cyc({tag, "_hit0"}, mk(S_HIT, 1'b0, 1'b1, m_lives, m_score));
        py = 3'd0;
        set_veh(8'h00);
        cyc({tag, "_hit1"}, mk(S_HIT, 1'b0, 1'b1, m_lives, m_score));
        cyc({tag, "_hit2"}, mk(S_HIT, 1'b0, 1'b0, m_lives, m_score));
        cyc({tag, "_hit3"}, mk(S_HIT, 1'b0, 1'b0, m_lives, m_score));
        m_lives = m_lives - 2'd1;
        if (m_lives == 2'd0) begin
            cyc({tag, "_over"}, mk(S_OVER, 1'b0, 1'b0, m_lives, m_score));
        end else begin
            cyc({tag, "_ret"},  mk(S_PLAY, 1'b1, 1'b0, m_lives, m_score));
            cyc({tag, "_play"}, mk(S_PLAY, 1'b0, 1'b0, m_lives, m_score));
        end
    endtask

    task automatic win_seq(input string tag);
        py = 3'd7;
        m_score = (m_score == 4'd15) ? m_score : m_score + 4'd1;
        cyc({tag, "_win0"}, mk(S_WIN, 1'b0, 1'b0, m_lives, m_score));
        py = 3'd0;
        cyc({tag, "_win1"}, mk(S_WIN, 1'b0, 1'b0, m_lives, m_score));
        cyc({tag, "_win2"}, mk(S_WIN, 1'b0, 1'b0, m_lives, m_score));
        cyc({tag, "_win3"}, mk(S_WIN, 1'b0, 1'b0, m_lives, m_score));
        cyc({tag, "_ret"},  mk(S_PLAY, 1'b1, 1'b0, m_lives, m_score));
        cyc({tag, "_play"}, mk(S_PLAY, 1'b0, 1'b0, m_lives, m_score));
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        now_chk("reset", mk(S_IDLE, 1'b0, 1'b0, 2'd0, 4'd0));
        rst = 1'b0;
        cyc("idle", mk(S_IDLE, 1'b0, 1'b0, 2'd0, 4'd0));

        // Start from IDLE
        start = 1'b1;
        m_lives = 2'd3;
        m_score = 4'd0;
        cyc("start", mk(S_PLAY, 1'b1, 1'b0, m_lives, m_score));
        start = 1'b0;
        cyc("play0", mk(S_PLAY, 1'b0, 1'b0, m_lives, m_score));

        // Near misses: adjacent bits/rows occupied, bank row fully occupied
        px = 3'd2; py = 3'd3;
        set_veh(8'hFF);
        veh3 = 8'b1111_1011;
        cyc("miss_bit", mk(S_PLAY, 1'b0, 1'b0, m_lives, m_score));
        py = 3'd0;
        set_veh(8'hFF);
        cyc("row0_safe", mk(S_PLAY, 1'b0, 1'b0, m_lives, m_score));
        set_veh(8'h00);

        // START edge in PLAY is ignored
        start = 1'b1;
        cyc("start_play", mk(S_PLAY, 1'b0, 1'b0, m_lives, m_score));
        start = 1'b0;
        cyc("play1", mk(S_PLAY, 1'b0, 1'b0, m_lives, m_score));

        // First collision: PX=2, PY=3, VEH3=0000_0100
        hit_seq("c1", 3'd2, 3'd3);

        // Crossing, with a START edge during WIN that must be ignored
        py = 3'd7;
        m_score = m_score + 4'd1;
        cyc("w1_win0", mk(S_WIN, 1'b0, 1'b0, m_lives, m_score));
        py = 3'd0;
        start = 1'b1;
        cyc("w1_win1", mk(S_WIN, 1'b0, 1'b0, m_lives, m_score));
        start = 1'b0;
        cyc("w1_win2", mk(S_WIN, 1'b0, 1'b0, m_lives, m_score));
        cyc("w1_win3", mk(S_WIN, 1'b0, 1'b0, m_lives, m_score));
        cyc("w1_ret",  mk(S_PLAY, 1'b1, 1'b0, m_lives, m_score));
        cyc("w1_play", mk(S_PLAY, 1'b0, 1'b0, m_lives, m_score));

        // Remaining lives lost on the boundary rows/columns
        hit_seq("c2", 3'd7, 3'd6);
        hit_seq("c3", 3'd0, 3'd1);
        cyc("over_stay", mk(S_OVER, 1'b0, 1'b0, m_lives, m_score));

        // START held high through OVER: exactly one restart
        start = 1'b1;
        m_lives = 2'd3;
        m_score = 4'd0;
        cyc("restart", mk(S_PLAY, 1'b1, 1'b0, m_lives, m_score));
        for (int i = 0; i < 3; i++) begin
            cyc($sformatf("held%0d", i), mk(S_PLAY, 1'b0, 1'b0, m_lives, m_score));
        end
        start = 1'b0;

        // 16 crossings saturate the score at 15
        for (int i = 0; i < 16; i++) begin
            win_seq($sformatf("x%0d", i));
        end

        // Bank row with every vehicle bit set never collides
        px = 3'd5; py = 3'd0;
        set_veh(8'hFF);
        cyc("row0_full", mk(S_PLAY, 1'b0, 1'b0, m_lives, m_score));
        cyc("row0_full2", mk(S_PLAY, 1'b0, 1'b0, m_lives, m_score));
        set_veh(8'h00);

        // Reset two cycles into HIT aborts the dwell
        px = 3'd4; py = 3'd5;
        set_veh(8'h10);
        cyc("r_hit0", mk(S_HIT, 1'b0, 1'b1, m_lives, m_score));
        py = 3'd0;
        set_veh(8'h00);
        cyc("r_hit1", mk(S_HIT, 1'b0, 1'b1, m_lives, m_score));
        rst = 1'b1;
        #1;
        now_chk("r_async", mk(S_IDLE, 1'b0, 1'b0, 2'd0, 4'd0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc($sformatf("r_idle%0d", i), mk(S_IDLE, 1'b0, 1'b0, 2'd0, 4'd0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
